// File: rtl/mult_8bit_pkg.sv
// Shared constants for the 8x8 shift-and-add multiplier: operand width,
// iteration count and FSM state encodings.
package mult_8bit_pkg;

  localparam int MULT_W    = 8;
  localparam int MULT_ITER = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Count value on the final iteration, when the product is committed
  localparam logic [2:0] CNT_LAST = 3'(MULT_ITER - 1);

  typedef logic [MULT_W-1:0]   word_t;
  typedef logic [2*MULT_W-1:0] prod_t;

endpackage

// File: rtl/mult_8bit_if.sv
// Start/busy/done handshake plus operand and product buses between the
// control unit (master) and the multiplier (slave).
interface mult_8bit_if;
  import mult_8bit_pkg::*;

  logic  start;
  word_t a;
  word_t b;
  logic  busy;
  logic  done;
  prod_t p;

  modport master (output start, output a, output b,
                  input busy, input done, input p);
  modport slave  (input start, input a, input b,
                  output busy, output done, output p);

endinterface

// File: rtl/addr_8bit.sv
// Ripple-carry 8-bit adder used for the multiplier's partial-product add;
// exposes the sum and the final carry-out c7.
module addr_8bit
  import mult_8bit_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  ci,
  output word_t sum,
  output logic  c7
);

  logic [MULT_W:0] carry_s;

  // Carry ripples from bit 0 upward through one full adder per bit
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    carry_s[0] = ci;
    for (int i = 0; i < MULT_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign c7 = carry_s[MULT_W];

endmodule

// File: rtl/mult_8bit.sv
// Unsigned 8x8 sequential shift-and-add multiplier, 8 cycles per product.
// Optional MULT_EARLY_EXIT_EN: zero operand completes at the accepting edge.
module mult_8bit
  import mult_8bit_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  mult_8bit_if.slave bus
);

  localparam int WIDTH = MULT_W;

  logic [0:0]         state_r;
  logic [WIDTH-1:0]   m_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   q_r;
  logic [2:0]         cnt_r;
  logic [2*WIDTH-1:0] p_r;
  logic               done_r;

  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic               c7_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic [WIDTH-1:0]   q_next_s;
  logic               zero_exit_s;

  addr_8bit u_addr (
    .a   (acc_r),
    .b   (addend_s),
    .ci  (1'b0),
    .sum (sum_s),
    .c7  (c7_s)
  );

  // Partial-product select and the right shift of {c7, sum, Q}
  always_comb begin
    addend_s   = q_r[0] ? m_r : 8'h00;
    acc_next_s = {c7_s, sum_s[WIDTH-1:1]};
    q_next_s   = {sum_s[0], q_r[WIDTH-1:1]};
  end

`ifdef MULT_EARLY_EXIT_EN
  assign zero_exit_s = (bus.a == 8'h00) || (bus.b == 8'h00);
`else
  assign zero_exit_s = 1'b0;
`endif

  // Sequencer: accept in IDLE, iterate in RUN, commit product on last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      m_r     <= 8'h00;
      acc_r   <= 8'h00;
      q_r     <= 8'h00;
      cnt_r   <= 3'd0;
      p_r     <= 16'h0000;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && zero_exit_s) begin
            p_r    <= 16'h0000;
            done_r <= 1'b1;
          end else if (bus.start) begin
            m_r     <= bus.a;
            q_r     <= bus.b;
            acc_r   <= 8'h00;
            cnt_r   <= 3'd0;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == CNT_LAST) begin
            p_r     <= {acc_next_s, q_next_s};
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state_r == ST_RUN);
  assign bus.done = done_r;
  assign bus.p    = p_r;

endmodule

// File: tb/tb_mult_8bit.sv
// Scoreboard bench for mult_8bit: directed operand pairs push expected
// product and completion cycle; a monitor checks each done pulse.
module tb_mult_8bit;

  typedef struct {
    logic [15:0] p;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  mult_8bit_if bus ();

  mult_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int lat_for(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_EARLY_EXIT_EN
    return (a == 8'h00 || b == 8'h00) ? 0 : 8;
`else
    return 8;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 with p=%h, expected no done", bus.p);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", 32'(bus.p), 32'(e.p));
        check("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    e.p   = exp_p;
    e.due = cyc + 1 + lat_for(a, b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_p", 32'(bus.p), 32'h0000);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;

    // Full scale: busy for exactly eight cycles
    issue(8'hFF, 8'hFF, 16'hFE01);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_run", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("done_pulse", 32'(bus.done), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back: second start in the done cycle, p holds meanwhile
    issue(8'h55, 8'hAA, 16'h3872);
    repeat (8) @(posedge clk);
    #1;
    check("b2b_done_high", 32'(bus.done), 32'd1);
    issue(8'h0D, 8'h0B, 16'h008F);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("p_hold", 32'(bus.p), 32'h3872);
    end
    @(posedge clk);
    #1;
    drain();

    // start while busy is ignored
    issue(8'h03, 8'h05, 16'h000F);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("ignored_start_p", 32'(bus.p), 32'h000F);
    @(posedge clk);
    #1;

    issue(8'h0C, 8'h0D, 16'h009C); drain();
    issue(8'h80, 8'h02, 16'h0100); drain();
    issue(8'hFF, 8'h01, 16'h00FF); drain();
    issue(8'h5A, 8'h00, 16'h0000); drain();
    issue(8'h07, 8'h09, 16'h003F); drain();

    // Zero multiplicand
    issue(8'h00, 8'h37, 16'h0000);
    @(negedge clk);
`ifdef MULT_EARLY_EXIT_EN
    check("zero_busy", 32'(bus.busy), 32'd0);
`else
    check("zero_busy", 32'(bus.busy), 32'd1);
`endif
    @(posedge clk);
    #1;
    drain();
    issue(8'h07, 8'h09, 16'h003F); drain();

    // Reset mid-operation aborts with no done
    issue(8'hFF, 8'hFF, 16'hFE01);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_p", 32'(bus.p), 32'h0000);
    check("abort_done", 32'(bus.done), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("post_abort_busy", 32'(bus.busy), 32'd0);
    check("post_abort_p", 32'(bus.p), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier end");
    $fatal(1, "watchdog expired");
  end

endmodule
